hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline-control counterpart to the IF/ID datapath. It consumes the decode-stage register addresses and control bits the datapath exports and returns StallF, StallD, FlushD and FlushE to it. It also returns EX-stage forwarding selects. It keeps its own shadow of destination-register state for the E, M and W stages, so no EX/MEM/WB pipeline registers need to be routed back. Two saturating counters report stall and flush activity.

## Interface
- CNT_W, 16, width of the stall and flush counters

- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- Rs1D  in  5  source register 1 of the instruction in D
- Rs2D  in  5  source register 2 of the instruction in D
- RdD  in  5  destination register of the instruction in D
- RegWriteD  in  1  instruction in D writes the register file
- ResultSrcD  in  2  result select of the instruction in D; 2'b01 marks a load
- PCSrcE  in  2  PC redirect from E; any nonzero value means a taken branch, jal or jalr
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID registers
- FlushD  out  1  clear IF/ID registers
- FlushE  out  1  clear ID/EX registers
- ForwardAE  out  2  ALU operand A select: 00 register file, 01 ResultW, 10 ALUResultM
- ForwardBE  out  2  ALU operand B select, same encoding as ForwardAE
- StallCount  out  CNT_W  number of cycles with StallD=1, saturating
- FlushCount  out  CNT_W  number of cycles with a redirect, saturating

## Operation
- Shadow state registers:
  - E stage: Rs1E, Rs2E, RdE, RegWriteE, LoadE.
  - M stage: RdM, RegWriteM.
  - W stage: RdW, RegWriteW.
- Register updates each clock:
  - If FlushE=1, the E slot is loaded with a bubble: all E fields are 0.
  - Otherwise the E slot loads Rs1D, Rs2D, RdD, RegWriteD, and LoadE = (ResultSrcD==2'b01).
  - M loads from E and W loads from M unconditionally; no stall is ever applied to E, M or W.
- redirect = (PCSrcE != 2'b00).
- lwStall = LoadE & RegWriteE & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
- Output equations:
  - StallF = StallD = lwStall & ~redirect. A redirect wins, because the instruction in D is squashed anyway.
  - FlushD = redirect.
  - FlushE = lwStall | redirect.
- ForwardAE:
  - 10 if RegWriteM & RdM != 0 & RdM == Rs1E.
  - Otherwise 01 if RegWriteW & RdW != 0 & RdW == Rs1E.
  - Otherwise 00.
  - M has priority over W. ForwardBE is identical, using Rs2E.
- Register x0 never triggers a stall or a forward.
- Counters:
  - StallCount increments on every cycle with StallD=1.
  - FlushCount increments on every cycle with redirect=1.
  - Both hold at 2^CNT_W-1 once reached.

## Timing
- rst=1 at a clock edge clears all shadow registers and both counters.
- While rst=1, every output is forced to 0. The datapath clears its own pipeline registers on reset.
- Control outputs are combinational from current state plus the D-stage and PCSrcE inputs, and are valid within the same cycle. Only the counters are registered.
- Load-use case:
  - Exactly one stall cycle is produced.
  - On the next edge the load moves to M and a bubble enters E, so lwStall drops.
  - The dependent instruction then sees ForwardxE=01 from W two cycles later. It never sees 10, because a load's value is not forwarded from M.
  - Load-to-M forwarding is excluded by construction: a load-dependent instruction is always separated by the bubble.
- Redirect case: FlushD and FlushE are asserted for the single cycle that PCSrcE is nonzero. Two bubbles follow.
- Redirect and lwStall in the same cycle: StallF=StallD=0, FlushD=FlushE=1, and StallCount does not increment.
- rst asserted mid-stall: the stall ends on that edge and the counters read 0 on the next cycle.

## Test plan
- ALU dependency:
  - Stimulus: add x5 enters D, then sub x6,x5,x1 follows.
  - Required: when sub is in E, ForwardAE=10 and ForwardBE=00. One cycle later, with an unrelated instruction in E, ForwardAE=00.
- Distance-2 dependency:
  - Stimulus: x7 is written, one independent instruction, then x7 is used as Rs2.
  - Required: ForwardBE=01 when the consumer is in E.
- Load-use:
  - Stimulus: lw x3 (ResultSrcD=01) in E, with Rs1D=3 in D.
  - Required: StallF=StallD=FlushE=1 for exactly one cycle; StallCount goes 0→1; the consumer later gets ForwardAE=01.
- x0 and double write:
  - Stimulus: writer to x0 followed by a reader of x0 → ForwardAE=00 and no stall.
  - Stimulus: x4 is written in both M and W.
  - Required for the double write: ForwardAE=10 (M priority).
- Redirect:
  - Stimulus: PCSrcE=01 for 1 cycle → FlushD=FlushE=1 and FlushCount=1.
  - Stimulus: PCSrcE=10 coincident with a load-use hazard.
  - Required for the coincident case: StallD=0, FlushE=1, StallCount unchanged.
- Saturation and reset:
  - Stimulus: CNT_W=2, 5 consecutive load-use stall cycles.
  - Required: StallCount reads 3 and holds.
  - Stimulus: then assert rst for 1 cycle.
  - Required: all outputs are 0 during reset and both counters read 0 afterwards.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, redirect flush and EX forwarding control with stall/flush activity counters
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic [1:0]       PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  logic [4:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic reg_write_e, load_e, reg_write_m, reg_write_w;
  logic redirect, lw_stall, stall, flush_e;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  assign redirect = |PCSrcE;
  assign lw_stall = load_e & reg_write_e & (rd_e != 5'd0) & ((rd_e == Rs1D) | (rd_e == Rs2D));
  assign stall    = lw_stall & ~redirect;
  assign flush_e  = lw_stall | redirect;
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    return (reg_write_m && rd_m != 5'd0 && rd_m == rs) ? 2'b10 :
           (reg_write_w && rd_w != 5'd0 && rd_w == rs) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    StallF     = ~rst & stall;
    StallD     = ~rst & stall;
    FlushD     = ~rst & redirect;
    FlushE     = ~rst & flush_e;
    ForwardAE  = rst ? 2'b00 : fwd(rs1_e);
    ForwardBE  = rst ? 2'b00 : fwd(rs2_e);
    StallCount = rst ? '0 : stall_cnt;
    FlushCount = rst ? '0 : flush_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {rs1_e, rs2_e, rd_e, reg_write_e, load_e} <= '0;
      {rd_m, reg_write_m, rd_w, reg_write_w}    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      rs1_e       <= flush_e ? 5'd0 : Rs1D;
      rs2_e       <= flush_e ? 5'd0 : Rs2D;
      rd_e        <= flush_e ? 5'd0 : RdD;
      reg_write_e <= ~flush_e & RegWriteD;
      load_e      <= ~flush_e & (ResultSrcD == 2'b01);
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (redirect && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vector table plus hand-written load-use saturation and reset sequences
module tb_hazard_unit;
  logic clk = 0, rst = 1;
  logic [4:0] Rs1D = 0, Rs2D = 0, RdD = 0;
  logic RegWriteD = 0;
  logic [1:0] ResultSrcD = 0, PCSrcE = 0;
  logic StallF, StallD, FlushD, FlushE, StallF2, StallD2, FlushD2, FlushE2;
  logic [1:0] ForwardAE, ForwardBE, ForwardAE2, ForwardBE2;
  logic [15:0] StallCount, FlushCount;
  logic [1:0] StallCount2, FlushCount2;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  hazard_unit dut (.clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
    .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallCount(StallCount),
    .FlushCount(FlushCount));

  hazard_unit #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE), .StallF(StallF2), .StallD(StallD2),
    .FlushD(FlushD2), .FlushE(FlushE2), .ForwardAE(ForwardAE2), .ForwardBE(ForwardBE2),
    .StallCount(StallCount2), .FlushCount(FlushCount2));

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       rw;
    logic [1:0] rsrc, pc;
    logic [7:0] ctl;
    int         sc, fc;
  } vec_t;
  vec_t v[$];

  function automatic logic [7:0] ctl_now();
    return {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [4:0] rs1, rs2, rd, input logic rw, input logic [1:0] rsrc, pc);
    Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; ResultSrcD = rsrc; PCSrcE = pc;
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [4:0] rs1, rs2, rd, input logic rw, input logic [1:0] rsrc, pc,
                     input logic [7:0] ctl, input int sc, fc);
    vec_t r;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.rw = rw; r.rsrc = rsrc; r.pc = pc;
    r.ctl = ctl; r.sc = sc; r.fc = fc;
    v.push_back(r);
  endtask

  initial begin
    // ctl = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}
    add( 2,  3,  5, 1, 0, 0, 8'b0000_0000, 0, 0);
    add( 5,  1,  6, 1, 0, 0, 8'b0000_0000, 0, 0);
    add( 9, 10,  8, 1, 0, 0, 8'b0000_1000, 0, 0);
    add( 0,  0,  7, 1, 0, 0, 8'b0000_0000, 0, 0);
    add(12, 13, 11, 1, 0, 0, 8'b0000_0000, 0, 0);
    add(15,  7, 14, 1, 0, 0, 8'b0000_0000, 0, 0);
    add(16, 17, 18, 1, 0, 0, 8'b0000_0001, 0, 0);
    add(20,  0,  3, 1, 1, 0, 8'b0000_0000, 0, 0);
    add( 3, 22, 21, 1, 0, 0, 8'b1101_0000, 0, 0);
    add( 3, 22, 21, 1, 0, 0, 8'b0000_0000, 1, 0);
    add(23, 24, 25, 1, 0, 0, 8'b0000_0100, 1, 0);
    add( 1,  2,  0, 1, 1, 0, 8'b0000_0000, 1, 0);
    add( 0,  0, 26, 1, 0, 0, 8'b0000_0000, 1, 0);
    add( 1,  2,  4, 1, 0, 0, 8'b0000_0000, 1, 0);
    add( 1,  2,  4, 1, 0, 0, 8'b0000_0000, 1, 0);
    add( 4,  5, 27, 1, 0, 0, 8'b0000_0000, 1, 0);
    add( 0,  0,  0, 0, 0, 0, 8'b0000_1000, 1, 0);
    add( 1,  2,  9, 1, 0, 1, 8'b0011_0000, 1, 0);
    add( 1,  2,  9, 1, 0, 0, 8'b0000_0000, 1, 1);
    add( 1,  2,  3, 1, 1, 0, 8'b0000_0000, 1, 1);
    add( 3,  0,  5, 1, 0, 2, 8'b0011_0000, 1, 1);
    add( 0,  0,  0, 0, 0, 0, 8'b0000_0000, 1, 2);

    drive(0, 0, 0, 0, 0, 0);
    check("reset ctl", ctl_now(), 0);
    check("reset cnt", {StallCount, FlushCount}, 0);
    next();
    next();
    rst = 0;
    foreach (v[i]) begin
      drive(v[i].rs1, v[i].rs2, v[i].rd, v[i].rw, v[i].rsrc, v[i].pc);
      check($sformatf("row%0d ctl", i), ctl_now(), v[i].ctl);
      check($sformatf("row%0d stallcnt", i), StallCount, v[i].sc);
      check($sformatf("row%0d flushcnt", i), FlushCount, v[i].fc);
      next();
    end

    for (int k = 0; k < 5; k++) begin
      drive(1, 2, 3, 1, 1, 0);
      next();
      drive(3, 0, 5, 1, 0, 0);
      check($sformatf("sat%0d stall", k), {StallF, StallD, FlushE}, 3'b111);
      check($sformatf("sat%0d cnt2", k), StallCount2, (k + 1 > 3) ? 3 : k + 1);
      next();
      drive(0, 0, 0, 0, 0, 0);
      next();
    end
    drive(0, 0, 0, 0, 0, 0);
    check("sat cnt16", StallCount, 6);
    check("sat cnt2", StallCount2, 3);
    next();
    drive(0, 0, 0, 0, 0, 0);
    check("sat hold cnt2", StallCount2, 3);
    check("sat hold flush2", FlushCount2, 2);
    next();

    drive(1, 2, 3, 1, 1, 0);
    next();
    rst = 1;
    drive(3, 0, 5, 1, 0, 2);
    check("rst ctl", ctl_now(), 0);
    check("rst cnt", {StallCount, FlushCount}, 0);
    check("rst dut2", {StallF2, StallD2, FlushD2, FlushE2, ForwardAE2, ForwardBE2, StallCount2, FlushCount2}, 0);
    next();
    rst = 0;
    drive(3, 0, 5, 1, 0, 0);
    check("post rst ctl", ctl_now(), 0);
    check("post rst cnt", {StallCount, FlushCount}, 0);
    check("post rst cnt2", {StallCount2, FlushCount2}, 0);
    next();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
